// File: rtl/bht_pkg.sv
// bht_pkg: shared row type, saturating counter and PC index helpers for the local-history BHT
package bht_pkg;
  localparam int BHT_HIST_BITS = 3;
  localparam int BHT_PC_W = 64;
  typedef struct packed {
    logic valid;
    logic [BHT_HIST_BITS-1:0] hist;
    logic [(1<<BHT_HIST_BITS)-1:0][1:0] ctr;
  } bht_row_t;
  function automatic logic [1:0] sat_cnt_update(input logic [1:0] ctr, input logic taken);
    return taken ? (ctr == 2'b11 ? ctr : ctr + 2'b01) : (ctr == 2'b00 ? ctr : ctr - 2'b01);
  endfunction
  function automatic logic [BHT_PC_W-1:0] bht_index(input logic [BHT_PC_W-1:0] pc, input int offset);
    return pc >> offset;
  endfunction
endpackage

// File: rtl/bht_ram_sp.sv
// bht_ram_sp: inferrable RAM with one write port and one registered read port
module bht_ram_sp #(
  parameter int DEPTH = 128,
  parameter int WIDTH = 8
) (
  input  logic                     clk_i,
  input  logic                     we,
  input  logic [$clog2(DEPTH)-1:0] waddr,
  input  logic [WIDTH-1:0]         wdata,
  input  logic [$clog2(DEPTH)-1:0] raddr,
  output logic [WIDTH-1:0]         rdata
);
  logic [WIDTH-1:0] mem [DEPTH];
  always_ff @(posedge clk_i) begin
    if (we) mem[waddr] <= wdata;
    rdata <= mem[raddr];
  end
endmodule

// File: rtl/bht_hist_ram.sv
// bht_hist_ram: RAM-backed local-history BHT with init sweep and forwarded two-stage update pipeline
module bht_hist_ram import bht_pkg::*; #(
  parameter int NR_ENTRIES = 128,
  parameter int HIST_BITS  = 3,
  parameter int VLEN       = 32,
  parameter int RVC        = 0
) (
  input  logic            clk_i,
  input  logic            rst_i,
  input  logic            flush_i,
  output logic            ready_o,
  input  logic            lookup_valid_i,
  input  logic [VLEN-1:0] lookup_pc_i,
  output logic            pred_valid_o,
  output logic            pred_taken_o,
  input  logic            upd_valid_i,
  input  logic [VLEN-1:0] upd_pc_i,
  input  logic            upd_taken_i
);
  localparam int IDX_W = $clog2(NR_ENTRIES);
  localparam int OFF = RVC ? 1 : 2;
  localparam int NCTR = 1 << HIST_BITS;
  typedef struct packed {
    logic valid;
    logic [HIST_BITS-1:0] hist;
    logic [NCTR-1:0][1:0] ctr;
  } row_t;
  typedef enum logic {INIT, RUN} state_t;
  state_t state, state_nxt;
  logic [IDX_W-1:0] sweep, sweep_nxt, lk_idx, up_idx, waddr, u0_idx, u1_idx;
  logic run, we, lk_v_q, lk_fwd_q, up_fwd_q, u0_v, u0_taken, u1_v, u1_taken;
  row_t rd_lk, rd_up, wdata, wd_q, lk_row, u0_row, u1_row, u1_base, u1_new;
  assign lk_idx = IDX_W'(bht_index(BHT_PC_W'(lookup_pc_i), OFF));
  assign up_idx = IDX_W'(bht_index(BHT_PC_W'(upd_pc_i), OFF));
  assign ready_o = state == RUN;
  assign run = (state == RUN) & ~flush_i & ~rst_i;
  always_comb begin
    state_nxt = flush_i ? INIT : (state == INIT && sweep == IDX_W'(NR_ENTRIES - 1)) ? RUN : state;
    sweep_nxt = (flush_i || state == RUN) ? '0 : sweep + 1'b1;
  end
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state  <= INIT;
      sweep  <= '0;
      lk_v_q <= 1'b0;
      u0_v   <= 1'b0;
      u1_v   <= 1'b0;
    end else begin
      state  <= state_nxt;
      sweep  <= sweep_nxt;
      lk_v_q <= run & lookup_valid_i;
      u0_v   <= run & upd_valid_i;
      u1_v   <= run & u0_v;
    end
  end
  // Both copies see the same write; a read hitting the address being written returns the new row.
  assign we = (state == INIT) | (u1_v & run);
  assign waddr = state == INIT ? sweep : u1_idx;
  assign wdata = state == INIT ? '0 : u1_new;
  always_ff @(posedge clk_i) begin
    lk_fwd_q <= we && waddr == lk_idx;
    up_fwd_q <= we && waddr == up_idx;
    wd_q     <= wdata;
    u0_idx   <= up_idx;
    u0_taken <= upd_taken_i;
    u1_idx   <= u0_idx;
    u1_taken <= u0_taken;
    u1_row   <= u0_row;
  end
  bht_ram_sp #(.DEPTH(NR_ENTRIES), .WIDTH($bits(row_t))) u_ram_lk (
    .clk_i(clk_i), .we(we), .waddr(waddr), .wdata(wdata), .raddr(lk_idx), .rdata(rd_lk)
  );
  bht_ram_sp #(.DEPTH(NR_ENTRIES), .WIDTH($bits(row_t))) u_ram_up (
    .clk_i(clk_i), .we(we), .waddr(waddr), .wdata(wdata), .raddr(up_idx), .rdata(rd_up)
  );
  assign u0_row = (u1_v && u1_idx == u0_idx) ? u1_new : up_fwd_q ? wd_q : rd_up;
  always_comb begin
    u1_base = u1_row;
    if (!u1_row.valid) begin
      u1_base.valid = 1'b1;
      u1_base.hist  = '0;
      u1_base.ctr   = {NCTR{2'b01}};
    end
    u1_new = u1_base;
    u1_new.ctr[u1_base.hist] = sat_cnt_update(u1_base.ctr[u1_base.hist], u1_taken);
    u1_new.hist = HIST_BITS'({u1_base.hist, u1_taken});
  end
  assign lk_row = lk_fwd_q ? wd_q : rd_lk;
  assign pred_valid_o = lk_v_q & lk_row.valid;
  assign pred_taken_o = pred_valid_o & lk_row.ctr[lk_row.hist][1];
endmodule
